// File: rtl/lsu_ctrl_if.sv
// Memory-side bus of the load/store controller.
// Build option: none (bus shape is the same with or without LSU_TIMEOUT_EN).
// Signals: mem_req/mem_we/mem_addr/mem_be/mem_wdata are driven by the LSU,
//          mem_ack/mem_rdata are returned by the data memory.
// Modports: master = LSU side, slave = memory side.
interface lsu_ctrl_if #(
    parameter int unsigned AW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller between the core and a variable-latency
// data memory. Issues one req/ack transaction per access and stalls the core
// until it completes. It also places store data on the byte lanes and
// sign/zero-extends load data.
// Optional macro LSU_TIMEOUT_EN: aborts a request after TIMEOUT cycles without
// ack and flags bus_err_o. Without the macro, REQ waits forever and bus_err_o = 0.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rd_en_i/wr_en_i load/store request (level, held while stalled)
//   funct3_i        access size/sign
//   addr_i          byte address
//   wdata_i         store data
//   stall_o         combinational core freeze
//   ld_data_o       extended load result (valid in DONE)
//   misalign_err_o  combinational illegal/misaligned flag in IDLE
//   bus_err_o       timeout abort pulse in DONE
//   mem             memory bus (lsu_ctrl_if.master)
module lsu_ctrl #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [2:0]        funct3_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       ld_data_o,
    output logic              misalign_err_o,
    output logic              bus_err_o,
    lsu_ctrl_if.master        mem
);
    localparam int unsigned CNT_W = 8;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("lsu_ctrl: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   mwdata_q, mwdata_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   ld_q, ld_d;

    logic          access, bad_f3, misaligned;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, ld_shift, ld_ext;

    // Request decode: store wins when both enables are high.
    always_comb begin
        access     = rd_en_i | wr_en_i;
        bad_f3     = wr_en_i ? (funct3_i[2] || funct3_i[1:0] == 2'b11)
                             : (funct3_i[1:0] == 2'b11 || funct3_i == 3'b110);
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    end

    // Store lane placement; loads always read the full word.
    always_comb begin
        lane_be    = 4'hF;
        lane_wdata = '0;
        if (wr_en_i) begin
            unique case (funct3_i[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << addr_i[1:0];
                    lane_wdata = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    lane_be    = 4'b0011 << addr_i[1:0];
                    lane_wdata = {2{wdata_i[15:0]}};
                end
                default: begin
                    lane_be    = 4'hF;
                    lane_wdata = wdata_i;
                end
            endcase
        end
    end

    // Load alignment and extension, using offset/funct3 captured at issue.
    always_comb begin
        ld_shift = mem.mem_rdata >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    // Next-state and combinational outputs.
    always_comb begin
        state_d        = state_q;
        req_d          = 1'b0;
        we_d           = we_q;
        maddr_d        = maddr_q;
        be_d           = be_q;
        mwdata_d       = mwdata_q;
        off_d          = off_q;
        f3_d           = f3_q;
        ld_d           = ld_q;
        stall_o        = 1'b0;
        misalign_err_o = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d          = cnt_q;
        bus_err_d      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (bad_f3 || misaligned) begin
                        misalign_err_o = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        state_d  = S_REQ;
                        req_d    = 1'b1;
                        we_d     = wr_en_i;
                        maddr_d  = {addr_i[AW-1:2], 2'b00};
                        be_d     = lane_be;
                        mwdata_d = lane_wdata;
                        off_d    = addr_i[1:0];
                        f3_d     = funct3_i;
`ifdef LSU_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (mem.mem_ack) begin
                    state_d = S_DONE;
                    ld_d    = we_q ? 32'd0 : ld_ext;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    ld_d      = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    req_d = 1'b1;
                end
`else
                end else begin
                    req_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Reset must silence the combinational outputs immediately.
        if (rst) begin
            stall_o        = 1'b0;
            misalign_err_o = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            be_q     <= '0;
            mwdata_q <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            ld_q     <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            ld_q     <= ld_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Request watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign ld_data_o     = ld_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mwdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases followed by randomized
// accesses, compared against a behavioural access model.
module tb_lsu_ctrl;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, misalign_err, bus_err;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_ld;

`ifdef LSU_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    lsu_ctrl_if #(.AW(32)) bus ();

    lsu_ctrl #(.AW(32), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en_i        (rd_en),
        .wr_en_i        (wr_en),
        .funct3_i       (funct3),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .stall_o        (stall),
        .ld_data_o      (ld_data),
        .misalign_err_o (misalign_err),
        .bus_err_o      (bus_err),
        .mem            (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Access legality from the ISA rules: size in bytes must divide the offset.
    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
        int n;
        bit ok;
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n  = 1 << f3[1:0];
        return ok && ((int'(off) % n) == 0);
    endfunction

    // Load result computed arithmetically from the read word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
        longint unsigned v;
        v = 64'(rdata) >> (8 * int'(off));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = v % 64'h1_0000_0000;
        endcase
        return 32'(v);
    endfunction

    // One full access; delay = REQ cycle index on which ack is returned.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay);
        bit          st, legal, abort;
        int          nbytes, n_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        @(posedge clk);
        @(negedge clk);
        st     = wr;
        legal  = model_legal(st, f3, a[1:0]);
        nbytes = 1 << f3[1:0];
        exp_be = st ? 4'(((1 << nbytes) - 1) << a[1:0]) : 4'hF;
        exp_wd = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
                 (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        if (!legal) begin
            check("misalign_err", 32'(misalign_err), 32'd1);
            check("stall_bad", 32'(stall), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("req_bad", 32'(bus.mem_req), 32'd0);
            check("ld_hold", ld_data, last_ld);
            rd_en = 1'b0; wr_en = 1'b0;
            return;
        end
        check("stall_idle", 32'(stall), 32'd1);
        check("misalign_ok", 32'(misalign_err), 32'd0);
        abort = TIMEOUT_EN && (delay > int'(TO) - 1);
        n_req = abort ? int'(TO) : delay + 1;
        for (int k = 0; k < n_req; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("req", 32'(bus.mem_req), 32'd1);
            check("stall_req", 32'(stall), 32'd1);
            check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            check("mem_we", 32'(bus.mem_we), 32'(st));
            check("mem_be", 32'(bus.mem_be), 32'(exp_be));
            if (st) check("mem_wdata", bus.mem_wdata, exp_wd);
            if (k == 1) begin
                addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
            end
            if (k == delay) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        exp_ld = (abort || st) ? 32'd0 : model_load(f3, a[1:0], rdata);
        check("req_done", 32'(bus.mem_req), 32'd0);
        check("stall_done", 32'(stall), 32'd0);
        check("bus_err", 32'(bus_err), 32'(abort));
        check("ld_data", ld_data, exp_ld);
        last_ld = exp_ld;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b1; wr_en = 1'b0; funct3 = 3'd2; addr = 32'h100; wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        last_ld = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_be", 32'(bus.mem_be), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);
        rd_en = 1'b0;
        rst = 1'b0;

        // Directed cases
        do_access(1, 0, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 0);
        do_access(1, 0, 3'd0, 32'h103, 0, 32'h80FF_0000, 0);
        do_access(1, 0, 3'd4, 32'h103, 0, 32'h80FF_0000, 0);
        do_access(1, 0, 3'd1, 32'h102, 0, 32'h80FF_0000, 0);
        do_access(0, 1, 3'd0, 32'h201, 32'h0000_00AB, 0, 0);
        do_access(0, 1, 3'd1, 32'h202, 32'h0000_1234, 0, 0);
        do_access(1, 0, 3'd2, 32'h101, 0, 0, 0);
        do_access(1, 0, 3'd3, 32'h100, 0, 0, 0);
        do_access(1, 1, 3'd1, 32'h302, 32'h0000_BEEF, 32'h1111_1111, 2);

        // Reset in the middle of a request; the late ack must be ignored
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1; funct3 = 3'd2; addr = 32'h400;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1; rd_en = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("late_ack_req", 32'(bus.mem_req), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_ld", ld_data, 32'd0);
        check("late_ack_buserr", 32'(bus_err), 32'd0);
        last_ld = '0;

        if (TIMEOUT_EN) begin
            do_access(1, 0, 3'd2, 32'h500, 0, 32'h1234_5678, 50);
            do_access(1, 0, 3'd2, 32'h504, 0, 32'hCAFE_F00D, 0);
            do_access(1, 0, 3'd5, 32'h506, 0, 32'hCAFE_F00D, int'(TO) - 1);
        end

        // Randomized accesses, some back-to-back
        for (int i = 0; i < 60; i++) begin
            logic r, w;
            r = 1'($urandom); w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_access(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 6)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencing controller between the core datapath and a variable-latency data memory.
- Takes rd_en/wr_en/funct3 from the control path and the ALU address, and runs a req/ack handshake to memory.
- Stalls the core until the access completes.
- Generates byte enables and write-data lane placement; sign/zero-extends load data for writeback.

Parameters:
- AW, 32, address width.
- TIMEOUT, 16, max REQ cycles before abort. Used only with the optional feature; legal range 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rd_en  in  1  load request from control path (level, held while stall=1)
- wr_en  in  1  store request from control path (level, held while stall=1)
- funct3  in  3  access size/sign, inst[14:12]
- addr  in  AW  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/regfile while high
- ld_data  out  32  extended load result, valid in DONE
- misalign_err  out  1  misaligned or illegal access, combinational pulse in IDLE
- bus_err  out  1  timeout abort, one-cycle pulse in DONE
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  memory completion, single-cycle
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, rst=1): state=IDLE. mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, bus_err, timeout counter all 0. stall and misalign_err forced 0 while rst=1.
- Reset mid-access drops mem_req immediately and discards the transaction. A late mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access = rd_en|wr_en. If both are high, wr_en wins (store).
  - Legal funct3 for loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. For stores: 000 sb, 001 sh, 010 sw.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Illegal funct3 or misaligned: misalign_err=1 combinationally, stall=0, no request, stay IDLE.
  - Legal access: stall=1 combinationally. At the clock edge, register mem_addr/mem_we/mem_be/mem_wdata, clear the counter, go to REQ.
- Store lane placement:
  - sb: be=0001<<addr[1:0], byte replicated to all lanes.
  - sh: be=0011<<addr[1:0], half replicated to both lanes.
  - sw: be=1111, data unshifted.
  - Loads use be=1111.
- REQ:
  - mem_req=1, stall=1.
  - On mem_ack: register ld_data = mem_rdata shifted right by 8*addr[1:0] (offset registered at issue), then sign- or zero-extended per funct3; go to DONE.
  - Stores load ld_data=0.
  - mem_ack outside REQ is ignored.
- DONE:
  - mem_req=0, stall=0, ld_data stable; core advances at this edge.
  - Always returns to IDLE next cycle. A back-to-back access is detected in the following IDLE.
- Latency:
  - With ack in the first REQ cycle, an access occupies 3 cycles (IDLE, REQ, DONE) with stall high for 2.
  - Each extra ack wait cycle adds one.
- Outputs mem_addr/mem_be/mem_wdata/mem_we hold their values from issue until the next issue.
- rd_en/wr_en/addr/funct3 changing during REQ have no effect; all fields are registered at issue.

Optional Feature:
- Macro: LSU_TIMEOUT_EN
- Defined:
  - An 8-bit counter increments each REQ cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, go to DONE with ld_data=0 and bus_err=1 for that DONE cycle.
  - Ack on the same cycle as expiry takes precedence: normal completion, bus_err=0.
- Undefined: no counter. REQ waits indefinitely. bus_err tied 0.

Test Plan:
- lw addr=0x100, mem_ack on first REQ cycle with mem_rdata=0xDEADBEEF:
  - stall 1,1,0 over 3 cycles; mem_be=1111; mem_addr=0x100.
  - ld_data=0xDEADBEEF in DONE.
- lb addr=0x103, mem_rdata=0x80FF_0000 → ld_data=0xFFFFFF80. lbu same → 0x00000080. lh addr=0x102 → 0xFFFF80FF.
- sb addr=0x0201, wdata=0x000000AB → mem_we=1, mem_be=0010, mem_wdata=0xABABABAB. sh addr=0x0202, wdata=0x1234 → be=1100, mem_wdata=0x12341234.
- lw addr=0x101 → misalign_err=1, stall=0, mem_req never asserts. funct3=011 load → same.
- lw with ack delayed 5 cycles; assert rst in the 3rd REQ cycle → mem_req falls immediately, state IDLE, a later ack is ignored, ld_data=0.
- LSU_TIMEOUT_EN, TIMEOUT=4, no ack → mem_req high for 4 cycles, then DONE with bus_err=1, ld_data=0, stall=0; next access proceeds normally.
